// File: rtl/hdr_ddr_bit_counter.sv
// ----------------------------------------------------------------------------
// hdr_ddr_bit_counter
//
// Registered SCL-edge bit counter for the HDR-DDR CCC path. It counts SCL
// edges (either polarity) within a frame. The frame length is run-time
// selectable between a normal DDR word (WORD_BITS) and a long error-recovery
// frame (LONG_BITS). Every output is driven directly by a flop.
//
// Optional feature: define HDR_DDR_BITCNT_WORD_CNT_EN to add a saturating
// completed-word counter and the o_word_count port.
//
// Ports
//   i_sys_clk        system clock, rising-edge active
//   i_rst            asynchronous active-high reset
//   i_bitcnt_en      counting enable; low clears count, flags and word count
//   i_scl_pos_edge   one-cycle pulse on SCL rising edge
//   i_scl_neg_edge   one-cycle pulse on SCL falling edge
//   i_long_mode      frame-length select (1 = LONG_BITS, 0 = WORD_BITS)
//   i_hold           freezes counter and frame length; edges are dropped
//   o_cnt_bit_count  current bit index, 0 .. terminal-1
//   o_word_done      one-cycle pulse when the count wraps to 0
//   o_last_bit       high while count == terminal-1
//   o_parity_window  high while count >= terminal-2
//   o_edge_err       one-cycle pulse when both edge inputs are high together
//   o_word_count     completed words, saturating (macro builds only)
// ----------------------------------------------------------------------------
module hdr_ddr_bit_counter #(
   parameter int unsigned CNT_W      = 6,
   parameter int unsigned WORD_BITS  = 20,
   parameter int unsigned LONG_BITS  = 38
`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
   ,
   parameter int unsigned WORD_CNT_W = 8
`endif
) (
   input  logic             i_sys_clk,
   input  logic             i_rst,
   input  logic             i_bitcnt_en,
   input  logic             i_scl_pos_edge,
   input  logic             i_scl_neg_edge,
   input  logic             i_long_mode,
   input  logic             i_hold,
   output logic [CNT_W-1:0] o_cnt_bit_count,
   output logic             o_word_done,
   output logic             o_last_bit,
   output logic             o_parity_window,
   output logic             o_edge_err
`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
   ,
   output logic [WORD_CNT_W-1:0] o_word_count
`endif
);

   if (LONG_BITS > (2 ** CNT_W)) begin : g_chk_long_fit
      $error("hdr_ddr_bit_counter: LONG_BITS must not exceed 2**CNT_W");
   end
   if (WORD_BITS < 3) begin : g_chk_word_min
      $error("hdr_ddr_bit_counter: WORD_BITS must be at least 3");
   end
   if (LONG_BITS < 3) begin : g_chk_long_min
      $error("hdr_ddr_bit_counter: LONG_BITS must be at least 3");
   end

   // Last index and first parity-window index of each frame type.
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_BITS - 1);
   localparam logic [CNT_W-1:0] WORD_PAR  = CNT_W'(WORD_BITS - 2);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_BITS - 1);
   localparam logic [CNT_W-1:0] LONG_PAR  = CNT_W'(LONG_BITS - 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             long_q, long_d;
   logic             done_q, done_d;
   logic             last_q, last_d;
   logic             par_q, par_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cur_last;
   logic [CNT_W-1:0] nxt_last;
   logic [CNT_W-1:0] nxt_par;
   logic             edge_ev;
`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
   logic [WORD_CNT_W-1:0] wcnt_q, wcnt_d;
`endif

   always_comb begin
      edge_ev  = i_scl_pos_edge | i_scl_neg_edge;
      cur_last = long_q ? LONG_LAST : WORD_LAST;
      cnt_d    = cnt_q;
      long_d   = long_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
      wcnt_d   = wcnt_q;
`endif
      if (!i_bitcnt_en) begin
         cnt_d  = '0;
         long_d = i_long_mode;
`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
         wcnt_d = '0;
`endif
      end else if (!i_hold && edge_ev) begin
         // Coincident edges still advance by one; they only raise the error.
         err_d = i_scl_pos_edge & i_scl_neg_edge;
         if (cnt_q == cur_last) begin
            cnt_d  = '0;
            done_d = 1'b1;
            long_d = i_long_mode;
`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
            if (wcnt_q != '1) begin
               wcnt_d = wcnt_q + WORD_CNT_W'(1);
            end
`endif
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      // Flags decode the next-state count against the next-state frame
      // length so they line up with the count they describe.
      nxt_last = long_d ? LONG_LAST : WORD_LAST;
      nxt_par  = long_d ? LONG_PAR  : WORD_PAR;
      last_d   = (cnt_d == nxt_last);
      par_d    = (cnt_d >= nxt_par);
   end

   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q  <= '0;
         long_q <= 1'b0;
         done_q <= 1'b0;
         last_q <= 1'b0;
         par_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         long_q <= long_d;
         done_q <= done_d;
         last_q <= last_d;
         par_q  <= par_d;
         err_q  <= err_d;
      end
   end

`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         wcnt_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
      end
   end

   assign o_word_count = wcnt_q;
`endif

   assign o_cnt_bit_count = cnt_q;
   assign o_word_done     = done_q;
   assign o_last_bit      = last_q;
   assign o_parity_window = par_q;
   assign o_edge_err      = err_q;

endmodule

// File: tb/tb_hdr_ddr_bit_counter.sv
// ----------------------------------------------------------------------------
// tb_hdr_ddr_bit_counter
//
// Self-checking bench for hdr_ddr_bit_counter. A frame-level reference model
// tracks the bit position, frame length and completed words with plain
// integer arithmetic; directed scenarios are followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_hdr_ddr_bit_counter;

   localparam int CNT_W      = 6;
   localparam int WORD_BITS  = 20;
   localparam int LONG_BITS  = 38;
   localparam int WORD_CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             pos = 1'b0;
   logic             neg = 1'b0;
   logic             lmode = 1'b0;
   logic             hold = 1'b0;
   logic [CNT_W-1:0] cnt;
   logic             wdone;
   logic             lastb;
   logic             parw;
   logic             eerr;
`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
   logic [WORD_CNT_W-1:0] wcount;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int m_cnt  = 0;
   int m_long = 0;
   int m_done = 0;
   int m_err  = 0;
   int m_wc   = 0;

   always #5 clk = ~clk;

   hdr_ddr_bit_counter #(
      .CNT_W      (CNT_W),
      .WORD_BITS  (WORD_BITS),
      .LONG_BITS  (LONG_BITS)
`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
      ,
      .WORD_CNT_W (WORD_CNT_W)
`endif
   ) dut (
      .i_sys_clk       (clk),
      .i_rst           (rst),
      .i_bitcnt_en     (en),
      .i_scl_pos_edge  (pos),
      .i_scl_neg_edge  (neg),
      .i_long_mode     (lmode),
      .i_hold          (hold),
      .o_cnt_bit_count (cnt),
      .o_word_done     (wdone),
      .o_last_bit      (lastb),
      .o_parity_window (parw),
      .o_edge_err      (eerr)
`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
      ,
      .o_word_count    (wcount)
`endif
   );

   task automatic chk_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int frame_len(input int lng);
      return (lng != 0) ? LONG_BITS : WORD_BITS;
   endfunction

   task automatic check_all();
      int t;
      t = frame_len(m_long);
      chk_eq("count",  int'(cnt),   m_cnt);
      chk_eq("done",   int'(wdone), m_done);
      chk_eq("last",   int'(lastb), (m_cnt == t - 1) ? 1 : 0);
      chk_eq("parity", int'(parw),  (m_cnt >= t - 2) ? 1 : 0);
      chk_eq("edgeerr", int'(eerr), m_err);
`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
      chk_eq("wordcnt", int'(wcount), m_wc);
`endif
   endtask

   // Apply one cycle of inputs, advance the model by the frame rules, compare.
   task automatic step(input bit s_en, input bit s_hold, input bit s_pos,
                       input bit s_neg, input bit s_lm);
      en = s_en; hold = s_hold; pos = s_pos; neg = s_neg; lmode = s_lm;
      @(posedge clk);
      #1;
      m_done = 0;
      m_err  = 0;
      if (!s_en) begin
         m_cnt  = 0;
         m_long = s_lm;
         m_wc   = 0;
      end else if (!s_hold && (s_pos || s_neg)) begin
         m_err = (s_pos && s_neg) ? 1 : 0;
         m_cnt = m_cnt + 1;
         if (m_cnt == frame_len(m_long)) begin
            m_cnt  = 0;
            m_done = 1;
            m_long = s_lm;
            if (m_wc < (1 << WORD_CNT_W) - 1) m_wc = m_wc + 1;
         end
      end
      check_all();
   endtask

   task automatic edges(input int n, input bit s_lm);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, ~i[0], i[0], s_lm);
   endtask

   task automatic async_reset();
      rst = 1'b1;
      #2;
      chk_eq("rst_count",  int'(cnt),   0);
      chk_eq("rst_done",   int'(wdone), 0);
      chk_eq("rst_last",   int'(lastb), 0);
      chk_eq("rst_parity", int'(parw),  0);
      chk_eq("rst_edgeerr", int'(eerr), 0);
`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
      chk_eq("rst_wordcnt", int'(wcount), 0);
`endif
      m_cnt = 0; m_long = 0; m_done = 0; m_err = 0; m_wc = 0;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // Power-on reset
      #12;
      check_all();
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_all();

      // Normal word: latch short mode, 20 alternating edges
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      edges(19, 1'b0);
      chk_eq("word_at19", int'(cnt), 19);
      chk_eq("word_last19", int'(lastb), 1);
      edges(1, 1'b0);
      chk_eq("word_wrap", int'(cnt), 0);
      chk_eq("word_done", int'(wdone), 1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_eq("word_done_pulse", int'(wdone), 0);

      // Long frame, mode toggled at count 10 must wait for the wrap
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      edges(10, 1'b1);
      edges(27, 1'b0);
      chk_eq("long_at37", int'(cnt), 37);
      edges(1, 1'b0);
      chk_eq("long_wrap", int'(wdone), 1);
      edges(19, 1'b0);
      chk_eq("after_long_short", int'(lastb), 1);
      edges(1, 1'b0);

      // Simultaneous edges at count 5
      edges(5, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      chk_eq("simul_count", int'(cnt), 6);
      chk_eq("simul_err", int'(eerr), 1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_eq("simul_err_pulse", int'(eerr), 0);

      // Hold at count 7 drops edges
      edges(1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk_eq("hold_count", int'(cnt), 7);
      edges(1, 1'b0);
      chk_eq("hold_release", int'(cnt), 8);

      // Async reset at count 12
      edges(4, 1'b0);
      async_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Enable drop at count 15
      edges(15, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_eq("en_drop", int'(cnt), 0);
      edges(1, 1'b0);
      chk_eq("en_first", int'(cnt), 1);

`ifdef HDR_DDR_BITCNT_WORD_CNT_EN
      // Saturating word counter over 300 short words
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int w = 0; w < 300; w++) edges(WORD_BITS, 1'b0);
      chk_eq("wc_sat", int'(wcount), 255);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_eq("wc_clear", int'(wcount), 0);
`endif

      // Randomized run
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) < 96),
              ($urandom_range(0, 99) < 10),
              ($urandom_range(0, 99) < 45),
              ($urandom_range(0, 99) < 45),
              ($urandom_range(0, 1) == 1));
         if ($urandom_range(0, 999) == 0) begin
            async_reset();
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
